// File: rtl/bldc_pwm_commutator_if.sv
// Signal bundle between the current loop / sensors and the BLDC PWM commutator.
// The master side drives references and sensors; the slave side returns gates and status.
interface bldc_pwm_commutator_if;
  logic        enable;
  logic [15:0] vref_q15;
  logic        dir;
  logic [2:0]  hall;
  logic        fault_n;
  logic        pwm_strobe;
  logic [2:0]  gate_h;
  logic [2:0]  gate_l;
  logic        hall_err;
  logic        fault_latched;

  modport master (
    output enable, vref_q15, dir, hall, fault_n,
    input  pwm_strobe, gate_h, gate_l, hall_err, fault_latched
  );

  modport slave (
    input  enable, vref_q15, dir, hall, fault_n,
    output pwm_strobe, gate_h, gate_l, hall_err, fault_latched
  );
endinterface

// File: rtl/bldc_pwm_commutator.sv
// Center-aligned PWM and six-step hall commutator with per-phase dead time
// and latched driver-fault shutdown. Also sources the per-period control strobe.
module bldc_pwm_commutator #(
  parameter int HALF_PERIOD = 2500,
  parameter int DEAD_CYCLES = 50
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bldc_pwm_commutator_if.slave bus
);
  localparam int CW = $clog2(HALF_PERIOD + 1);
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam int PW = 15 + CW;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  localparam logic [CW-1:0] C_HALF = CW'(HALF_PERIOD);
  localparam logic [DW-1:0] C_DEAD = DW'(DEAD_CYCLES);

  logic [CW-1:0]       r_cnt;
  logic                r_cnt_down;
  logic                r_strobe;
  logic [14:0]         r_vref_sh;
  logic                r_dir_sh;
  logic [2:0]          r_hall_s1;
  logic [2:0]          r_hall_s2;
  logic                r_fault_s1;
  logic                r_fault_s2;
  logic                r_fault_latched;
  logic                r_hall_err;
  logic [2:0][1:0]     r_state;
  logic [2:0][DW-1:0]  r_dead;
  logic [2:0]          r_gate_h;
  logic [2:0]          r_gate_l;

  logic [CW-1:0]       w_cnt_next;
  logic                w_cnt_down_next;
  logic [14:0]         w_vref_clamp;
  logic [PW-1:0]       w_product;
  logic [CW-1:0]       w_duty;
  logic                w_pwm_raw;
  logic [2:0]          w_tab_pos;
  logic [2:0]          w_tab_neg;
  logic [2:0]          w_pos;
  logic [2:0]          w_neg;
  logic                w_hall_bad;
  logic                w_force_off;
  logic [2:0][1:0]     w_desired;
  logic [2:0][1:0]     w_state_next;
  logic [2:0][DW-1:0]  w_dead_next;

  // Triangle: up 0..HALF_PERIOD, down HALF_PERIOD-1..1, then back to 0.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_cnt_next      = r_cnt + 1'b1;
    w_cnt_down_next = r_cnt_down;
    if (!r_cnt_down) begin
      if (r_cnt == C_HALF) begin
        w_cnt_next      = C_HALF - 1'b1;
        w_cnt_down_next = 1'b1;
      end
    end else begin
      w_cnt_next = r_cnt - 1'b1;
      if (r_cnt == CW'(1)) w_cnt_down_next = 1'b0;
    end
  end

  assign w_vref_clamp = bus.vref_q15[15] ? 15'h7FFF : bus.vref_q15[14:0];
  assign w_product    = PW'(r_vref_sh) * PW'(C_HALF);
  assign w_duty       = w_product[PW-1:15];
  assign w_pwm_raw    = (r_cnt < w_duty);

  // Forward table as one-hot {C,B,A}: pos carries PWM, neg is held low.
  always_comb begin
    w_tab_pos = 3'b000;
    w_tab_neg = 3'b000;
    case (r_hall_s2)
      3'b101:  begin w_tab_pos = 3'b001; w_tab_neg = 3'b010; end
      3'b100:  begin w_tab_pos = 3'b001; w_tab_neg = 3'b100; end
      3'b110:  begin w_tab_pos = 3'b010; w_tab_neg = 3'b100; end
      3'b010:  begin w_tab_pos = 3'b010; w_tab_neg = 3'b001; end
      3'b011:  begin w_tab_pos = 3'b100; w_tab_neg = 3'b001; end
      3'b001:  begin w_tab_pos = 3'b100; w_tab_neg = 3'b010; end
      default: begin w_tab_pos = 3'b000; w_tab_neg = 3'b000; end
    endcase
  end

  assign w_pos       = r_dir_sh ? w_tab_pos : w_tab_neg;
  assign w_neg       = r_dir_sh ? w_tab_neg : w_tab_pos;
  assign w_hall_bad  = (r_hall_s2 == 3'b000) || (r_hall_s2 == 3'b111);
  assign w_force_off = !bus.enable || r_fault_latched || !r_fault_s2;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_desired[i] = ST_OFF;
      if (w_pos[i])      w_desired[i] = w_pwm_raw ? ST_HIGH : ST_LOW;
      else if (w_neg[i]) w_desired[i] = ST_LOW;
    end
  end

  // Entering HIGH or LOW always passes through DEAD; OFF is taken at once.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_state_next[i] = r_state[i];
      w_dead_next[i]  = r_dead[i];
      if (w_force_off || (w_desired[i] == ST_OFF)) begin
        w_state_next[i] = ST_OFF;
      end else if (r_state[i] == ST_DEAD) begin
        if (r_dead[i] <= DW'(1)) w_state_next[i] = w_desired[i];
        else                     w_dead_next[i]  = r_dead[i] - 1'b1;
      end else if (w_desired[i] != r_state[i]) begin
        w_state_next[i] = ST_DEAD;
        w_dead_next[i]  = C_DEAD;
      end
    end
  end

  // NOTE: registers are written with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt           <= '0;
      r_cnt_down      <= 1'b0;
      r_strobe        <= 1'b0;
      r_vref_sh       <= '0;
      r_dir_sh        <= 1'b1;
      r_hall_s1       <= '0;
      r_hall_s2       <= '0;
      r_fault_s1      <= 1'b0;
      r_fault_s2      <= 1'b0;
      r_fault_latched <= 1'b0;
      r_hall_err      <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_cnt_down <= w_cnt_down_next;
      r_strobe   <= (w_cnt_next == '0);
      if (r_cnt == '0) begin
        r_vref_sh <= w_vref_clamp;
        r_dir_sh  <= bus.dir;
      end
      r_hall_s1  <= bus.hall;
      r_hall_s2  <= r_hall_s1;
      r_fault_s1 <= bus.fault_n;
      r_fault_s2 <= r_fault_s1;
      if (!r_fault_s2)      r_fault_latched <= 1'b1;
      else if (!bus.enable) r_fault_latched <= 1'b0;
      r_hall_err <= w_hall_bad;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= {3{ST_OFF}};
      r_dead   <= '0;
      r_gate_h <= '0;
      r_gate_l <= '0;
    end else begin
      r_state <= w_state_next;
      r_dead  <= w_dead_next;
      for (int i = 0; i < 3; i++) begin
        r_gate_h[i] <= (w_state_next[i] == ST_HIGH);
        r_gate_l[i] <= (w_state_next[i] == ST_LOW);
      end
    end
  end

  assign bus.pwm_strobe    = r_strobe;
  assign bus.gate_h        = r_gate_h;
  assign bus.gate_l        = r_gate_l;
  assign bus.hall_err      = r_hall_err;
  assign bus.fault_latched = r_fault_latched;
endmodule
